// File: rtl/regfile_write_arbiter.sv
// Writeback arbiter: merges load and ALU results through a small FIFO, drives the
// register file write port one entry per cycle, and forwards pending writes to decode.
module regfile_write_arbiter #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 4
) (
   input  logic                       iClk,
   input  logic                       iRst,
   input  logic                       iAluValid,
   output logic                       oAluReady,
   input  logic [ADDRESS_WIDTH-1:0]   iAluRd,
   input  logic [DATA_WIDTH-1:0]      iAluData,
   input  logic                       iLoadValid,
   output logic                       oLoadReady,
   input  logic [ADDRESS_WIDTH-1:0]   iLoadRd,
   input  logic [DATA_WIDTH-1:0]      iLoadData,
   output logic                       oWriteEn,
   output logic [ADDRESS_WIDTH-1:0]   oWriteAddress,
   output logic [DATA_WIDTH-1:0]      oWriteData,
   input  logic [ADDRESS_WIDTH-1:0]   iReadAddress1,
   input  logic [ADDRESS_WIDTH-1:0]   iReadAddress2,
   output logic                       oFwdHit1,
   output logic                       oFwdHit2,
   output logic [DATA_WIDTH-1:0]      oFwdData1,
   output logic [DATA_WIDTH-1:0]      oFwdData2,
   output logic [$clog2(DEPTH):0]     oCount,
   output logic                       oEmpty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [ADDRESS_WIDTH-1:0] rd_mem_q   [DEPTH];
   logic [DATA_WIDTH-1:0]    data_mem_q [DEPTH];
   logic [PTR_W-1:0]         head_q, tail_q;
   logic [CNT_W-1:0]         count_q, count_d;
   logic                     wr_en_q;
   logic [ADDRESS_WIDTH-1:0] wr_addr_q;
   logic [DATA_WIDTH-1:0]    wr_data_q;

   logic                     full_s, load_fire_s, alu_fire_s, push_s, pop_s;
   logic [ADDRESS_WIDTH-1:0] push_rd_s;
   logic [DATA_WIDTH-1:0]    push_data_s;

   // Full uses current occupancy only, so a same-cycle pop never frees a slot.
   assign full_s      = (count_q == CNT_W'(DEPTH));
   assign oLoadReady  = !full_s && !iRst;
   assign oAluReady   = !full_s && !iLoadValid && !iRst;
   assign load_fire_s = iLoadValid && oLoadReady;
   assign alu_fire_s  = iAluValid && oAluReady;
   assign pop_s       = (count_q != CNT_W'(0));

   always_comb begin
      if (load_fire_s) begin
         push_rd_s   = iLoadRd;
         push_data_s = iLoadData;
      end else begin
         push_rd_s   = iAluRd;
         push_data_s = iAluData;
      end
   end

   // Writes to x0 complete the handshake but never occupy a slot.
   assign push_s = (load_fire_s || alu_fire_s) && (push_rd_s != ADDRESS_WIDTH'(0));

   always_comb begin
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         head_q    <= PTR_W'(0);
         tail_q    <= PTR_W'(0);
         count_q   <= CNT_W'(0);
         wr_en_q   <= 1'b0;
         wr_addr_q <= ADDRESS_WIDTH'(0);
         wr_data_q <= DATA_WIDTH'(0);
      end else begin
         count_q <= count_d;
         wr_en_q <= pop_s;
         if (push_s) begin
            tail_q <= tail_q + PTR_W'(1);
         end
         if (pop_s) begin
            head_q    <= head_q + PTR_W'(1);
            wr_addr_q <= rd_mem_q[head_q];
            wr_data_q <= data_mem_q[head_q];
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (push_s) begin
         rd_mem_q[tail_q]   <= push_rd_s;
         data_mem_q[tail_q] <= push_data_s;
      end
   end

   // Oldest-to-youngest scan so the newest matching entry is the last to overwrite.
   function automatic logic [DATA_WIDTH:0] fwd_lookup(input logic [ADDRESS_WIDTH-1:0] addr);
      logic             hit;
      logic [DATA_WIDTH-1:0] data;
      logic [PTR_W-1:0] idx;
      hit  = 1'b0;
      data = DATA_WIDTH'(0);
      if (addr != ADDRESS_WIDTH'(0)) begin
         if (wr_en_q && (wr_addr_q == addr)) begin
            hit  = 1'b1;
            data = wr_data_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (rd_mem_q[idx] == addr)) begin
               hit  = 1'b1;
               data = data_mem_q[idx];
            end
         end
      end
      return {hit, data};
   endfunction

   always_comb begin
      {oFwdHit1, oFwdData1} = fwd_lookup(iReadAddress1);
      {oFwdHit2, oFwdData2} = fwd_lookup(iReadAddress2);
   end

   assign oWriteEn      = wr_en_q;
   assign oWriteAddress = wr_addr_q;
   assign oWriteData    = wr_data_q;
   assign oCount        = count_q;
   assign oEmpty        = !pop_s && !wr_en_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Writeback-side counterpart of the register file. Drives the register file's single write port (write enable, write address, write data).
- Merges result streams from the ALU path and the load path through a small FIFO and drains one write per cycle.
- Discards writes to x0.
- Gives decode a combinational forwarding lookup over writes that are accepted but not yet committed.

Parameters:
- ADDRESS_WIDTH, 5, register index width.
- DATA_WIDTH, 32, register data width.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  synchronous reset, active-high.
- iAluValid  input  1  ALU result request.
- oAluReady  output  1  ALU request accepted this cycle when high together with iAluValid.
- iAluRd  input  ADDRESS_WIDTH  ALU destination register.
- iAluData  input  DATA_WIDTH  ALU result.
- iLoadValid  input  1  load result request.
- oLoadReady  output  1  load request accepted this cycle when high together with iLoadValid.
- iLoadRd  input  ADDRESS_WIDTH  load destination register.
- iLoadData  input  DATA_WIDTH  load result.
- oWriteEn  output  1  register file write enable.
- oWriteAddress  output  ADDRESS_WIDTH  register file write address.
- oWriteData  output  DATA_WIDTH  register file write data.
- iReadAddress1  input  ADDRESS_WIDTH  forwarding lookup address, port 1.
- iReadAddress2  input  ADDRESS_WIDTH  forwarding lookup address, port 2.
- oFwdHit1  output  1  a pending write matches iReadAddress1.
- oFwdHit2  output  1  a pending write matches iReadAddress2.
- oFwdData1  output  DATA_WIDTH  youngest pending data for iReadAddress1; 0 when no hit.
- oFwdData2  output  DATA_WIDTH  youngest pending data for iReadAddress2; 0 when no hit.
- oCount  output  $clog2(DEPTH)+1  FIFO occupancy.
- oEmpty  output  1  FIFO empty and no write in flight.

Behaviour:
- Reset (iRst=1 at an edge):
  - FIFO pointers and count go to 0; all pending entries are dropped.
  - oWriteEn, oWriteAddress, oWriteData go to 0.
  - oCount=0, oEmpty=1.
  - Requests presented in the reset cycle are not accepted.
  - Reset mid-drain leaves no partial write: oWriteEn is 0 in the following cycle.
- Ready (combinational):
  - oLoadReady = !full && !iRst.
  - oAluReady = !full && !iLoadValid && !iRst.
  - Load has fixed priority. At most one request is accepted per cycle.
  - Full is evaluated on current occupancy; a pop in the same cycle does not free a slot for a push.
- Enqueue:
  - An accepted request with rd!=0 is written at the tail on the edge; count increments.
  - rd==0: the handshake completes, but nothing is enqueued or written.
- Drain:
  - On each edge with count>0, the head entry is popped into the output register. oWriteEn=1 with that address and data for exactly one cycle.
  - If count==0, oWriteEn=0 (address and data hold their last values).
  - Minimum latency: request accepted at edge N -> oWriteEn high in the cycle after edge N+1.
  - Sustained throughput is 1 write per cycle.
- Simultaneous push and pop: count unchanged; entry ordering is preserved (FIFO, no reordering between sources).
- Pointer wrap: modulo DEPTH; full when count==DEPTH, empty when count==0.
- Forwarding (combinational):
  - Searches the in-flight output register (when oWriteEn=1) and all valid FIFO entries.
  - The youngest match wins: newest FIFO entry first, then older entries, then the output register.
  - A lookup address of 0 never hits.
  - Requests being accepted in the current cycle are not visible to the lookup.
- oEmpty = (count==0) && !oWriteEn.

Test Plan:
- Reset then single write: ALU valid, rd=5, data=0xDEADBEEF at edge 1 -> oWriteEn=1, addr=5, data=0xDEADBEEF in the cycle after edge 2, then oWriteEn=0 and oEmpty=1.
- Priority: both valid in the same cycle (load rd=3 data=0x11, ALU rd=4 data=0x22), ALU held valid -> oLoadReady=1, oAluReady=0; writes appear in the order rd=3 then rd=4 on consecutive cycles.
- Full and backpressure: 6 back-to-back ALU requests (rd=1..6, data=rd*0x10) -> all six written in order rd=1..6 with no loss and no duplication; oCount never exceeds 4; oAluReady low whenever oCount==4.
- x0 discard: ALU rd=0 data=0xFFFFFFFF -> handshake completes, oWriteEn stays 0, oCount stays 0.
- Forwarding: enqueue rd=7 data=0xA, then rd=7 data=0xB, with iReadAddress1=7 and iReadAddress2=0 -> oFwdHit1=1 with oFwdData1=0xB; oFwdHit2=0 with oFwdData2=0. After both writes drain -> oFwdHit1=0.
- Mid-operation reset: 3 entries pending, assert iRst for one edge -> next cycle oWriteEn=0, oCount=0, oEmpty=1; no further writes occur.
